// File: rtl/mem_bank_2rw_arb.sv
// mem_bank_2rw_arb: round-robin scheduler that shares one two-port masked
// memory bank among NUM_REQ requesters. Up to two non-conflicting requests
// are granted per cycle, issued from registers onto RW0/RW1, and read data
// is routed back to the owning requester one edge after issue.
module mem_bank_2rw_arb #(
    parameter int NUM_REQ   = 4,
    parameter int REG_DEPTH = 4,
    parameter int REG_WIDTH = 64,
    localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1,
    localparam int W  = REG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_wmode,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*W-1:0]  req_wmask,
    input  logic [NUM_REQ*W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [NUM_REQ*W-1:0]  rsp_rdata,
    output logic                  RW0_wmode,
    output logic [AW-1:0]         RW0_addr,
    output logic [W-1:0]          RW0_wmask,
    output logic [W-1:0]          RW0_wdata,
    input  logic [W-1:0]          RW0_rdata,
    output logic                  RW1_wmode,
    output logic [AW-1:0]         RW1_addr,
    output logic [W-1:0]          RW1_wmask,
    output logic [W-1:0]          RW1_wdata,
    input  logic [W-1:0]          RW1_rdata
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Per-requester views of the flattened request buses.
    logic [AW-1:0] addr_arr [NUM_REQ];
    logic [W-1:0]  mask_arr [NUM_REQ];
    logic [W-1:0]  data_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*AW +: AW];
        assign mask_arr[gi] = req_wmask[gi*W +: W];
        assign data_arr[gi] = req_wdata[gi*W +: W];
    end

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           a_found, b_found;
    logic [IDW-1:0] a_idx, b_idx;

    // Issue-stage registers, one set per memory port.
    logic           iv0_q, iv1_q;
    logic [IDW-1:0] own0_q, own1_q;
    logic           wm0_q, wm1_q;
    logic [AW-1:0]  addr0_q, addr1_q;
    logic [W-1:0]   mask0_q, mask1_q, data0_q, data1_q;

    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [NUM_REQ-1:0] hit0, hit1;

    // Round-robin scan from ptr: first valid wins port 0, the next valid one
    // that does not clash with it wins port 1; clashing requesters are skipped.
    always_comb begin : p_arb
        int             cand;
        int             nxt;
        logic [IDW-1:0] idx;
        logic [IDW-1:0] last;
        a_found   = 1'b0;
        b_found   = 1'b0;
        a_idx     = '0;
        b_idx     = '0;
        cand      = 0;
        nxt       = 0;
        idx       = '0;
        last      = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            idx = IDW'(cand);
            if (req_valid[idx]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = idx;
                end else if (!b_found && (NUM_REQ > 1) &&
                             !((addr_arr[idx] == addr_arr[a_idx]) &&
                               (req_wmode[idx] | req_wmode[a_idx]))) begin
                    b_found = 1'b1;
                    b_idx   = idx;
                end
            end
        end
        if (a_found) req_ready[a_idx] = 1'b1;
        if (b_found) req_ready[b_idx] = 1'b1;
        // Slot B is always later in scan order, so it is the last grant.
        last = b_found ? b_idx : a_idx;
        nxt  = int'(last) + 1;
        if (nxt >= NUM_REQ) nxt = 0;
        ptr_d = a_found ? IDW'(nxt) : ptr_q;
    end

    // Load issue registers from the winners; an empty slot issues an idle read of 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            iv0_q   <= 1'b0;
            iv1_q   <= 1'b0;
            own0_q  <= '0;
            own1_q  <= '0;
            wm0_q   <= 1'b0;
            wm1_q   <= 1'b0;
            addr0_q <= '0;
            addr1_q <= '0;
            mask0_q <= '0;
            mask1_q <= '0;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            iv0_q   <= a_found;
            own0_q  <= a_idx;
            wm0_q   <= a_found & req_wmode[a_idx];
            addr0_q <= a_found ? addr_arr[a_idx] : '0;
            mask0_q <= a_found ? mask_arr[a_idx] : '0;
            data0_q <= a_found ? data_arr[a_idx] : '0;
            iv1_q   <= b_found;
            own1_q  <= b_idx;
            wm1_q   <= b_found & req_wmode[b_idx];
            addr1_q <= b_found ? addr_arr[b_idx] : '0;
            mask1_q <= b_found ? mask_arr[b_idx] : '0;
            data1_q <= b_found ? data_arr[b_idx] : '0;
        end
    end

    assign RW0_wmode = wm0_q & iv0_q;
    assign RW0_addr  = addr0_q;
    assign RW0_wmask = mask0_q;
    assign RW0_wdata = data0_q;
    assign RW1_wmode = wm1_q & iv1_q;
    assign RW1_addr  = addr1_q;
    assign RW1_wmask = mask1_q;
    assign RW1_wdata = data1_q;

    // Per-requester response capture; a requester owns at most one port per cycle.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
        logic [W-1:0] rsp_rdata_q;

        assign hit0[gi] = iv0_q & ~wm0_q & (own0_q == IDW'(gi));
        assign hit1[gi] = iv1_q & ~wm1_q & (own1_q == IDW'(gi));

        // Hold the last read data until the next response to this requester.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rsp_rdata_q <= '0;
            end else if (hit0[gi]) begin
                rsp_rdata_q <= RW0_rdata;
            end else if (hit1[gi]) begin
                rsp_rdata_q <= RW1_rdata;
            end
        end

        assign rsp_rdata[gi*W +: W] = rsp_rdata_q;
    end

    // One-cycle response pulse for every read that was on a port last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= '0;
        end else begin
            rsp_valid_q <= hit0 | hit1;
        end
    end

    assign rsp_valid = rsp_valid_q;

endmodule
